// File: rtl/pin_pattern_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pin_pattern_pkg
// Brief   : Shared types and sizing helpers for the pin pattern driver.
// Revision: 1.0 - initial release
// ============================================================================
package pin_pattern_pkg;

    localparam int DURW_DEF  = 8;
    localparam int DEPTH_DEF = 4;
    localparam int PTRW      = $clog2(DEPTH_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic                level;
        logic [DURW_DEF-1:0] duration;
    } entry_t;

    // Pointer width for a FIFO of the given depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pin_pattern_driver_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pin_pattern_driver_if
// Brief   : Command handshake and pin/status bundle for the pattern driver.
// Revision: 1.0 - initial release
// ============================================================================
interface pin_pattern_driver_if #(
    parameter int DURW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_level;
    logic [DURW-1:0] cmd_duration;
    logic            pin;
    logic            positiveedge;
    logic            negativeedge;
    logic            busy;
    logic            empty;

    modport master (
        output cmd_valid, cmd_level, cmd_duration,
        input  cmd_ready, pin, positiveedge, negativeedge, busy, empty
    );

    modport slave (
        input  cmd_valid, cmd_level, cmd_duration,
        output cmd_ready, pin, positiveedge, negativeedge, busy, empty
    );
endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : cmd_fifo
// Brief   : Synchronous power-of-two FIFO with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_fifo
    import pin_pattern_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic                          push_i,
    input  wire logic [WIDTH-1:0]              data_i,
    input  wire logic                          pop_i,
    output logic      [WIDTH-1:0]              data_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic      [ptr_width(DEPTH):0]     count_o
);
    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/pin_pattern_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pin_pattern_driver
// Brief   : Plays queued {level, duration} commands onto a registered pin.
// Revision: 1.0 - initial release
// ============================================================================
module pin_pattern_driver
    import pin_pattern_pkg::*;
#(
    parameter int   DURW       = DURW_DEF,
    parameter int   DEPTH      = DEPTH_DEF,
    parameter int   MIN_HOLD   = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    pin_pattern_driver_if.slave bus
);
    localparam int             EW         = DURW + 1;
    localparam int             CW         = ptr_width(DEPTH) + 1;
    localparam logic [DURW-1:0] MIN_HOLD_C = DURW'(MIN_HOLD);

    logic [EW-1:0]   wr_data, rd_data;
    logic            rd_level;
    logic [DURW-1:0] rd_dur, eff_dur;
    logic            push, pop, full, fifo_empty;
    logic [CW-1:0]   count;

    state_t          state_q, state_d;
    logic [DURW-1:0] cnt_q, cnt_d;
    logic            pin_q, pin_d;
    logic            pos_q, pos_d;
    logic            neg_q, neg_d;

    assign wr_data = {bus.cmd_level, bus.cmd_duration};
    assign push    = bus.cmd_valid && !full;

    cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (wr_data),
        .pop_i   (pop),
        .data_o  (rd_data),
        .full_o  (full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign rd_level = rd_data[DURW];
    assign rd_dur   = rd_data[DURW-1:0];
    assign eff_dur  = (rd_dur < MIN_HOLD_C) ? MIN_HOLD_C : rd_dur;

    // The counter holds the remaining cycles after the current one, so a
    // pop loads eff-1 and the next entry is taken on the edge it reaches 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    pin_d   = rd_level;
                    cnt_d   = eff_dur - DURW'(1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DURW'(1);
                end else if (!fifo_empty) begin
                    pop   = 1'b1;
                    pin_d = rd_level;
                    cnt_d = eff_dur - DURW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pos_d = pin_d & ~pin_q;
        neg_d = ~pin_d & pin_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pin_q   <= IDLE_LEVEL;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.pin          = pin_q;
    assign bus.positiveedge = pos_q;
    assign bus.negativeedge = neg_q;
    assign bus.busy         = (state_q == DRIVE) || (count != '0);
    assign bus.empty        = fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_pin_pattern_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pin_pattern_driver
// Brief   : Scoreboard bench: DUT A (MIN_HOLD=1) and DUT B (MIN_HOLD=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pin_pattern_driver;

    localparam int MINH_A = 1;
    localparam int MINH_B = 3;
    localparam int BUDGET = 2000;

    logic clk;
    logic reset_n;

    pin_pattern_driver_if #(.DURW(8)) ifa ();
    pin_pattern_driver_if #(.DURW(8)) ifb ();

    pin_pattern_driver #(.DURW(8), .DEPTH(4), .MIN_HOLD(MINH_A), .IDLE_LEVEL(1'b0)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    pin_pattern_driver #(.DURW(8), .DEPTH(4), .MIN_HOLD(MINH_B), .IDLE_LEVEL(1'b0)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit q0[$];
    bit q1[$];
    bit prev[2];
    int npos[2];
    int nneg[2];

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int idx, input bit v, input bit l, input logic [7:0] d);
        if (idx == 0) begin
            ifa.cmd_valid = v; ifa.cmd_level = l; ifa.cmd_duration = d;
        end else begin
            ifb.cmd_valid = v; ifb.cmd_level = l; ifb.cmd_duration = d;
        end
    endtask

    function automatic bit rdy(input int idx);
        return (idx == 0) ? ifa.cmd_ready : ifb.cmd_ready;
    endfunction

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    // Expected pin waveform: eff copies of the level per accepted command.
    task automatic sb_push(input int idx, input bit lvl, input int dur);
        int minh = (idx == 0) ? MINH_A : MINH_B;
        int eff  = (dur < minh) ? minh : dur;
        for (int i = 0; i < eff; i++) begin
            if (idx == 0) q0.push_back(lvl);
            else          q1.push_back(lvl);
        end
    endtask

    task automatic sb_step(input int idx, input bit pin, input bit pos, input bit neg);
        bit e;
        bit have;
        string nm = (idx == 0) ? "A" : "B";
        have = (qsize(idx) != 0);
        if (have) e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        else      e = prev[idx];
        chk_eq({nm, ".pin"}, 32'(pin), 32'(e));
        chk_eq({nm, ".positiveedge"}, 32'(pos), 32'(e & ~prev[idx]));
        chk_eq({nm, ".negativeedge"}, 32'(neg), 32'(~e & prev[idx]));
        if (pos) npos[idx]++;
        if (neg) nneg[idx]++;
        prev[idx] = e;
    endtask

    always @(posedge clk) begin
        bit acc_a, acc_b, lv_a, lv_b, rst_ok;
        int du_a, du_b;
        rst_ok = reset_n;
        acc_a  = ifa.cmd_valid && ifa.cmd_ready;
        acc_b  = ifb.cmd_valid && ifb.cmd_ready;
        lv_a = ifa.cmd_level; du_a = int'(ifa.cmd_duration);
        lv_b = ifb.cmd_level; du_b = int'(ifb.cmd_duration);
        #1;
        if (rst_ok && reset_n) begin
            sb_step(0, ifa.pin, ifa.positiveedge, ifa.negativeedge);
            sb_step(1, ifb.pin, ifb.positiveedge, ifb.negativeedge);
            if (acc_a) sb_push(0, lv_a, du_a);
            if (acc_b) sb_push(1, lv_b, du_b);
        end
    end

    task automatic send(input int idx, input bit lvl, input int dur, output int waited);
        waited = 0;
        @(negedge clk);
        drive(idx, 1'b1, lvl, dur[7:0]);
        while (!rdy(idx) && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= BUDGET) chk_eq("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    task automatic release_cmd(input int idx);
        @(negedge clk);
        drive(idx, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic wait_idle(input int idx, input bit exp_pin);
        int t = 0;
        string nm = (idx == 0) ? "A" : "B";
        while (((idx == 0 ? ifa.busy : ifb.busy) || qsize(idx) != 0) && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk_eq({nm, ".idle_timeout"}, 32'(t >= BUDGET), 32'd0);
        @(negedge clk);
        chk_eq({nm, ".idle_busy"},  32'(idx == 0 ? ifa.busy  : ifb.busy),  32'd0);
        chk_eq({nm, ".idle_empty"}, 32'(idx == 0 ? ifa.empty : ifb.empty), 32'd1);
        chk_eq({nm, ".idle_pin"},   32'(idx == 0 ? ifa.pin   : ifb.pin),   32'(exp_pin));
    endtask

    task automatic chk_reset_state(input string nm, input bit pin, input bit pos, input bit neg,
                                   input bit busy, input bit empty, input bit ready);
        chk_eq({nm, ".rst_pin"},   32'(pin),   32'd0);
        chk_eq({nm, ".rst_pos"},   32'(pos),   32'd0);
        chk_eq({nm, ".rst_neg"},   32'(neg),   32'd0);
        chk_eq({nm, ".rst_busy"},  32'(busy),  32'd0);
        chk_eq({nm, ".rst_empty"}, 32'(empty), 32'd1);
        chk_eq({nm, ".rst_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int p0, n0;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd0);
        drive(1, 1'b0, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        chk_reset_state("A", ifa.pin, ifa.positiveedge, ifa.negativeedge, ifa.busy, ifa.empty, ifa.cmd_ready);
        chk_reset_state("B", ifb.pin, ifb.positiveedge, ifb.negativeedge, ifb.busy, ifb.empty, ifb.cmd_ready);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back: rise one edge after the push, fall 3 cycles later.
        send(0, 1'b1, 3, w);
        send(0, 1'b0, 2, w);
        release_cmd(0);
        wait_idle(0, 1'b0);

        // Glitch pattern with a single-cycle high pulse.
        p0 = npos[0]; n0 = nneg[0];
        send(0, 1'b0, 10, w);
        send(0, 1'b1, 1, w);
        send(0, 1'b0, 10, w);
        send(0, 1'b1, 10, w);
        release_cmd(0);
        wait_idle(0, 1'b1);
        chk_eq("glitch_pos_count", 32'(npos[0] - p0), 32'd2);
        chk_eq("glitch_neg_count", 32'(nneg[0] - n0), 32'd1);

        // Full FIFO behind a long hold; the fifth push must stall.
        send(0, 1'b1, 50, w);
        release_cmd(0);
        repeat (3) @(negedge clk);
        send(0, 1'b0, 2, w); chk_eq("full_push1_wait", 32'(w), 32'd0);
        send(0, 1'b1, 3, w); chk_eq("full_push2_wait", 32'(w), 32'd0);
        send(0, 1'b0, 1, w); chk_eq("full_push3_wait", 32'(w), 32'd0);
        send(0, 1'b1, 2, w); chk_eq("full_push4_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk_eq("full_ready", 32'(ifa.cmd_ready), 32'd0);
        chk_eq("full_empty", 32'(ifa.empty), 32'd0);
        chk_eq("full_busy",  32'(ifa.busy), 32'd1);
        drive(0, 1'b1, 1'b0, 8'd4);
        w = 0;
        while (!ifa.cmd_ready && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        chk_eq("full_push5_stalled", 32'(w >= 30 && w < BUDGET), 32'd1);
        release_cmd(0);
        wait_idle(0, 1'b0);

        // Clamp on DUT B: durations 0 and 1 become 3.
        p0 = npos[1]; n0 = nneg[1];
        send(1, 1'b1, 0, w);
        send(1, 1'b0, 1, w);
        release_cmd(1);
        wait_idle(1, 1'b0);
        chk_eq("clamp_pos_count", 32'(npos[1] - p0), 32'd1);
        chk_eq("clamp_neg_count", 32'(nneg[1] - n0), 32'd1);

        // Same-level merge: one rising strobe, 8 cycles high.
        p0 = npos[0]; n0 = nneg[0];
        send(0, 1'b1, 4, w);
        send(0, 1'b1, 4, w);
        release_cmd(0);
        wait_idle(0, 1'b1);
        chk_eq("merge_pos_count", 32'(npos[0] - p0), 32'd1);
        chk_eq("merge_neg_count", 32'(nneg[0] - n0), 32'd0);

        // Reset in the middle of a long hold.
        send(0, 1'b1, 200, w);
        send(0, 1'b0, 5, w);
        release_cmd(0);
        repeat (20) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk_reset_state("A", ifa.pin, ifa.positiveedge, ifa.negativeedge, ifa.busy, ifa.empty, ifa.cmd_ready);
        q0.delete();
        q1.delete();
        prev[0] = 1'b0;
        prev[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("post_rst_pin",  32'(ifa.pin),  32'd0);
        chk_eq("post_rst_busy", 32'(ifa.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pin_pattern_driver.md
Name: pin_pattern_driver

Overview:
- Drive-side counterpart of the input conditioner.
- Accepts a queue of {level, duration} commands and drives a single registered output pin through the resulting waveform. Each level is held an exact number of clk cycles.
- Generates clean, bounce-free, or deliberately glitchy stimulus for a conditioner input.
- Reports its own output edges with one-cycle strobes, mirroring the conditioner's positiveedge/negativeedge.

Parameters:
- DURW, 8, width of the duration field in cycles.
- DEPTH, 4, command FIFO depth; power of two, ≥2.
- MIN_HOLD, 1, minimum effective hold in cycles. Durations below this are raised to MIN_HOLD; range 1..2^DURW-1.
- IDLE_LEVEL, 0, pin value after reset.

Ports:
- clk, input, 1, single system clock; all logic on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, a command is presented.
- cmd_ready, output, 1, FIFO can accept a command; equals !full.
- cmd_level, input, 1, level to drive.
- cmd_duration, input, DURW, hold length in cycles.
- pin, output, 1, registered driven signal.
- positiveedge, output, 1, one-cycle strobe in the cycle pin first shows 1 after 0.
- negativeedge, output, 1, one-cycle strobe in the cycle pin first shows 0 after 1.
- busy, output, 1, high in DRIVE or whenever the FIFO is non-empty.
- empty, output, 1, FIFO empty.

Behaviour:
- Reset (async assert, sync release), all applied immediately: pin=IDLE_LEVEL, positiveedge=0, negativeedge=0, FIFO flushed, empty=1, cmd_ready=1, busy=0, counter=0, state=IDLE.
- Reset mid-operation aborts the current hold and discards all queued commands.
- Accept rule: a command is pushed on any edge where cmd_valid && cmd_ready. cmd_ready is combinational !full, with no bypass path. When full, cmd_ready=0 and cmd_valid is ignored; nothing is dropped or overwritten.
- Effective duration eff = (cmd_duration < MIN_HOLD) ? MIN_HOLD : cmd_duration. Duration 0 therefore becomes MIN_HOLD.
- States: IDLE and DRIVE.
  - IDLE: pin holds its last level. If the FIFO is non-empty, pop on this edge: pin<=level, counter<=eff-1, go to DRIVE.
  - DRIVE, counter≠0: decrement the counter.
  - DRIVE, counter=0 and FIFO non-empty: pop the next entry on the same edge (back-to-back, no gap cycle) and stay in DRIVE.
  - DRIVE, counter=0 and FIFO empty: go to IDLE; pin keeps its value.
- Timing: each entry's level is visible on pin for exactly eff cycles, then the next entry's level appears. A command pushed at edge k into an empty FIFO while IDLE appears on pin at edge k+1.
- Same-level consecutive entries simply concatenate; no edge strobes are produced.
- Edge strobes are registered alongside pin:
  - positiveedge=1 for exactly one cycle when new pin=1 and old pin=0.
  - negativeedge=1 for exactly one cycle when new pin=0 and old pin=1.
  - The two strobes are never high together.
- Simultaneous push and pop in one cycle: both occur. Occupancy is unchanged, and the FIFO pointers wrap modulo DEPTH.
- The counter never underflows; the maximum hold is 2^DURW-1 cycles.

Decomposition:
- Shared package pin_pattern_pkg holds:
  - the state enum {IDLE, DRIVE};
  - the entry type {level, duration[DURW-1:0]};
  - the localparam for pointer width, log2(DEPTH).
- Sub-module cmd_fifo: synchronous FIFO with push/pop, full/empty, an occupancy count of width log2(DEPTH)+1, and async active-low reset on reset_n.
- Top level contains the FSM, the hold counter, the pin register, and the edge-strobe logic.

Test Plan:
- Reset check: assert reset_n=0 mid-hold of a {1,200} command → pin=0, busy=0, empty=1, cmd_ready=1 immediately, before the next clk edge. Release reset; pin stays 0.
- Glitch pattern, matching the conditioner bench (20 ns clk): push {0,10},{1,1},{0,10},{1,10} → pin 0 for 10 cycles, 1 for exactly 1 cycle, 0 for 10, then 1 for 10. positiveedge pulses twice and negativeedge once, each strobe 1 cycle wide. Then IDLE with pin=1, busy=0.
- Back-to-back timing: push {1,3} then {0,2} → rise at edge k+1, fall exactly 3 cycles later, no gap cycle. After 2 more cycles, IDLE with pin=0.
- Full FIFO: with DEPTH=4, push 5 commands while DRIVE holds a {1,50} → cmd_ready=0 after 4 stored entries; the 5th is not accepted until the first pop. All accepted commands play in order.
- Clamp: MIN_HOLD=3, push {1,0} and {0,1} → each level held exactly 3 cycles.
- Same-level merge: push {1,4},{1,4} → pin high for 8 cycles with a single positiveedge strobe.
